// File: rtl/alarm_ring_sequencer.sv
// Alarm ring sequencer: beeps the buzzer on a fixed on/off cadence after a ring
// request, handles stop and limited snooze, and auto-stops an unattended ring.
module alarm_ring_sequencer #(
  parameter int BEEP_ON_MS     = 200,
  parameter int BEEP_OFF_MS    = 300,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk_1k,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       ring_req,
  input  logic       btn_stop,
  input  logic       btn_snooze,
  output logic       buzzer,
  output logic       ring_active,
  output logic       snoozing,
  output logic [8:0] snooze_left,
  output logic [1:0] snooze_count,
  output logic       ring_done,
  output logic       timed_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RING_ON  = 2'd1,
    RING_OFF = 2'd2,
    SNOOZE   = 2'd3
  } state_t;

  localparam logic [9:0] ON_LAST    = 10'(BEEP_ON_MS - 1);
  localparam logic [9:0] OFF_LAST   = 10'(BEEP_OFF_MS - 1);
  localparam logic [6:0] RING_LAST  = 7'(RING_TIMEOUT_S - 1);
  localparam logic [8:0] SNOOZE_LEN = 9'(SNOOZE_S);
  localparam logic [1:0] SNOOZE_MAX = 2'(MAX_SNOOZE);

  state_t     state, state_d;
  logic [9:0] beep_cnt, beep_cnt_d;
  logic [6:0] ring_sec, ring_sec_d;
  logic [8:0] snooze_left_d;
  logic [1:0] snooze_count_d;
  logic       buzzer_d, ring_active_d, snoozing_d, ring_done_d, timed_out_d;

  logic       ringing, stop_ev, snooze_ev, timeout_ev, wake_ev;
  logic [9:0] phase_last;

  // Event decode, already filtered by state so priority below stays simple.
  always_comb begin
    ringing    = (state == RING_ON) || (state == RING_OFF);
    stop_ev    = btn_stop && (state != IDLE);
    snooze_ev  = btn_snooze && ringing && (snooze_count < SNOOZE_MAX);
    timeout_ev = ringing && tick_1hz && (ring_sec == RING_LAST);
    wake_ev    = (state == SNOOZE) && tick_1hz && (snooze_left == 9'd1);
    phase_last = (state == RING_ON) ? ON_LAST : OFF_LAST;
  end

  always_ff @(posedge clk_1k or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      beep_cnt     <= '0;
      ring_sec     <= '0;
      snooze_left  <= '0;
      snooze_count <= '0;
      buzzer       <= 1'b0;
      ring_active  <= 1'b0;
      snoozing     <= 1'b0;
      ring_done    <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      state        <= state_d;
      beep_cnt     <= beep_cnt_d;
      ring_sec     <= ring_sec_d;
      snooze_left  <= snooze_left_d;
      snooze_count <= snooze_count_d;
      buzzer       <= buzzer_d;
      ring_active  <= ring_active_d;
      snoozing     <= snoozing_d;
      ring_done    <= ring_done_d;
      timed_out    <= timed_out_d;
    end
  end

  // Next state and counters; order of the if-chain encodes event priority.
  always_comb begin
    state_d        = state;
    beep_cnt_d     = beep_cnt;
    ring_sec_d     = ring_sec;
    snooze_left_d  = snooze_left;
    snooze_count_d = snooze_count;
    case (state)
      IDLE: begin
        if (ring_req) begin
          state_d        = RING_ON;
          beep_cnt_d     = '0;
          ring_sec_d     = '0;
          snooze_count_d = '0;
        end
      end
      RING_ON, RING_OFF: begin
        if (stop_ev) begin
          state_d        = IDLE;
          beep_cnt_d     = '0;
          ring_sec_d     = '0;
          snooze_count_d = '0;
        end else if (snooze_ev) begin
          state_d        = SNOOZE;
          beep_cnt_d     = '0;
          ring_sec_d     = '0;
          snooze_left_d  = SNOOZE_LEN;
          snooze_count_d = snooze_count + 2'd1;
        end else if (timeout_ev) begin
          state_d    = IDLE;
          beep_cnt_d = '0;
          ring_sec_d = '0;
        end else begin
          if (tick_1hz) ring_sec_d = ring_sec + 7'd1;
          if (beep_cnt == phase_last) begin
            beep_cnt_d = '0;
            state_d    = (state == RING_ON) ? RING_OFF : RING_ON;
          end else begin
            beep_cnt_d = beep_cnt + 10'd1;
          end
        end
      end
      SNOOZE: begin
        if (stop_ev) begin
          state_d        = IDLE;
          snooze_left_d  = '0;
          snooze_count_d = '0;
        end else if (wake_ev) begin
          state_d       = RING_ON;
          snooze_left_d = '0;
          beep_cnt_d    = '0;
          ring_sec_d    = '0;
        end else if (tick_1hz) begin
          snooze_left_d = snooze_left - 9'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output values are derived from the next state so they register in step with it.
  always_comb begin
    buzzer_d      = (state_d == RING_ON);
    ring_active_d = (state_d == RING_ON) || (state_d == RING_OFF);
    snoozing_d    = (state_d == SNOOZE);
    ring_done_d   = stop_ev || (timeout_ev && !snooze_ev);
    timed_out_d   = timed_out;
    if (state == IDLE && ring_req) timed_out_d = 1'b0;
    else if (timeout_ev && !stop_ev && !snooze_ev) timed_out_d = 1'b1;
  end

endmodule

// File: tb/tb_alarm_ring_sequencer.sv
// Directed bench for alarm_ring_sequencer: cadence, timeout, snooze limits,
// button priority and reset behaviour, with hand-computed expectations.
`timescale 1ns/1ps
module tb_alarm_ring_sequencer;

  logic       clk_1k = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       ring_req = 1'b0;
  logic       btn_stop = 1'b0;
  logic       btn_snooze = 1'b0;
  logic       buzzer, ring_active, snoozing, ring_done, timed_out;
  logic [8:0] snooze_left;
  logic [1:0] snooze_count;

  int checks = 0;
  int failures = 0;
  int high_cnt;

  alarm_ring_sequencer dut (
    .clk_1k       (clk_1k),
    .rst          (rst),
    .tick_1hz     (tick_1hz),
    .ring_req     (ring_req),
    .btn_stop     (btn_stop),
    .btn_snooze   (btn_snooze),
    .buzzer       (buzzer),
    .ring_active  (ring_active),
    .snoozing     (snoozing),
    .snooze_left  (snooze_left),
    .snooze_count (snooze_count),
    .ring_done    (ring_done),
    .timed_out    (timed_out)
  );

  always #5 clk_1k = ~clk_1k;

  task automatic cycle();
    @(posedge clk_1k);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    // Reset state
    cycles(3);
    check_output("rst_buzzer", 32'(buzzer), 0);
    check_output("rst_active", 32'(ring_active), 0);
    check_output("rst_snooze_left", 32'(snooze_left), 0);
    check_output("rst_ring_done", 32'(ring_done), 0);
    check_output("rst_timed_out", 32'(timed_out), 0);

    // Ring accepted on the first edge after reset release, then cadence
    rst = 1'b0; ring_req = 1'b1; cycle(); ring_req = 1'b0;
    check_output("start_active", 32'(ring_active), 1);
    check_output("start_buzzer", 32'(buzzer), 1);
    high_cnt = 0;
    for (int i = 1; i <= 500; i++) begin
      cycle();
      if (buzzer) high_cnt++;
      if (i == 199) check_output("on_last", 32'(buzzer), 1);
      if (i == 200) check_output("off_first", 32'(buzzer), 0);
      if (i == 499) check_output("off_last", 32'(buzzer), 0);
      if (i == 500) check_output("on_again", 32'(buzzer), 1);
    end
    check_output("period_high_cnt", 32'(high_cnt), 200);

    // Timeout on the 60th tick
    tick_1hz = 1'b1; cycles(59); tick_1hz = 1'b0;
    check_output("pre_timeout_active", 32'(ring_active), 1);
    check_output("pre_timeout_done", 32'(ring_done), 0);
    tick_1hz = 1'b1; cycle(); tick_1hz = 1'b0;
    check_output("timeout_active", 32'(ring_active), 0);
    check_output("timeout_done", 32'(ring_done), 1);
    check_output("timeout_flag", 32'(timed_out), 1);
    check_output("timeout_buzzer", 32'(buzzer), 0);
    cycle();
    check_output("timeout_done_pulse", 32'(ring_done), 0);
    check_output("timeout_sticky", 32'(timed_out), 1);

    // Snooze after 1000 cycles and wake after 300 ticks
    ring_req = 1'b1; cycle(); ring_req = 1'b0;
    check_output("ring2_active", 32'(ring_active), 1);
    check_output("ring2_timed_out_clr", 32'(timed_out), 0);
    check_output("ring2_count", 32'(snooze_count), 0);
    cycles(1000);
    btn_snooze = 1'b1; cycle(); btn_snooze = 1'b0;
    check_output("snz1_snoozing", 32'(snoozing), 1);
    check_output("snz1_buzzer", 32'(buzzer), 0);
    check_output("snz1_active", 32'(ring_active), 0);
    check_output("snz1_left", 32'(snooze_left), 300);
    check_output("snz1_count", 32'(snooze_count), 1);
    tick_1hz = 1'b1; cycle(); tick_1hz = 1'b0;
    check_output("snz1_left_299", 32'(snooze_left), 299);
    tick_1hz = 1'b1; cycles(298); tick_1hz = 1'b0;
    check_output("snz1_left_1", 32'(snooze_left), 1);
    check_output("snz1_still", 32'(snoozing), 1);
    tick_1hz = 1'b1; cycle(); tick_1hz = 1'b0;
    check_output("wake_active", 32'(ring_active), 1);
    check_output("wake_buzzer", 32'(buzzer), 1);
    check_output("wake_snoozing", 32'(snoozing), 0);
    check_output("wake_left", 32'(snooze_left), 0);

    // Two more snoozes reach the limit; a fourth is ignored
    for (int k = 0; k < 2; k++) begin
      btn_snooze = 1'b1; cycle(); btn_snooze = 1'b0;
      check_output("snz_count", 32'(snooze_count), 32'(k + 2));
      tick_1hz = 1'b1; cycles(300); tick_1hz = 1'b0;
      check_output("snz_rewake", 32'(buzzer), 1);
    end
    btn_snooze = 1'b1; cycle(); btn_snooze = 1'b0;
    check_output("snz4_ignored", 32'(snoozing), 0);
    check_output("snz4_active", 32'(ring_active), 1);
    check_output("snz4_count", 32'(snooze_count), 3);
    cycles(198);
    check_output("snz4_on_last", 32'(buzzer), 1);
    cycle();
    check_output("snz4_off_first", 32'(buzzer), 0);

    // Stop beats snooze in the same cycle
    btn_stop = 1'b1; btn_snooze = 1'b1; cycle(); btn_stop = 1'b0; btn_snooze = 1'b0;
    check_output("stop_snz_active", 32'(ring_active), 0);
    check_output("stop_snz_done", 32'(ring_done), 1);
    check_output("stop_snz_count", 32'(snooze_count), 0);
    check_output("stop_snz_snoozing", 32'(snoozing), 0);
    check_output("stop_snz_timed_out", 32'(timed_out), 0);
    cycle();
    check_output("stop_done_pulse", 32'(ring_done), 0);

    // Reset in the middle of a snooze
    ring_req = 1'b1; cycle(); ring_req = 1'b0;
    btn_snooze = 1'b1; cycle(); btn_snooze = 1'b0;
    tick_1hz = 1'b1; cycles(150); tick_1hz = 1'b0;
    check_output("mid_snz_left", 32'(snooze_left), 150);
    rst = 1'b1; #1;
    check_output("async_snoozing", 32'(snoozing), 0);
    check_output("async_left", 32'(snooze_left), 0);
    check_output("async_count", 32'(snooze_count), 0);
    check_output("async_active", 32'(ring_active), 0);
    check_output("async_done", 32'(ring_done), 0);
    cycle();
    check_output("rst_no_done", 32'(ring_done), 0);
    rst = 1'b0; ring_req = 1'b1; cycle(); ring_req = 1'b0;
    check_output("fresh_active", 32'(ring_active), 1);
    check_output("fresh_buzzer", 32'(buzzer), 1);
    check_output("fresh_count", 32'(snooze_count), 0);
    cycles(199);
    check_output("fresh_on_last", 32'(buzzer), 1);
    cycle();
    check_output("fresh_off_first", 32'(buzzer), 0);

    // Extra ring_req in RING_OFF changes neither phase nor elapsed seconds
    tick_1hz = 1'b1; cycles(30); tick_1hz = 1'b0;
    ring_req = 1'b1; cycle(); ring_req = 1'b0;
    check_output("extra_req_buzzer", 32'(buzzer), 0);
    check_output("extra_req_active", 32'(ring_active), 1);
    tick_1hz = 1'b1; cycles(29); tick_1hz = 1'b0;
    cycles(239);
    check_output("extra_off_last", 32'(buzzer), 0);
    cycle();
    check_output("extra_on_again", 32'(buzzer), 1);
    check_output("extra_no_done", 32'(ring_done), 0);
    tick_1hz = 1'b1; cycle(); tick_1hz = 1'b0;
    check_output("extra_timeout_done", 32'(ring_done), 1);
    check_output("extra_timeout_flag", 32'(timed_out), 1);
    check_output("extra_timeout_active", 32'(ring_active), 0);

    // Buttons in IDLE, ring_req with stop, stop during snooze
    btn_stop = 1'b1; cycle(); btn_stop = 1'b0;
    check_output("idle_stop_no_done", 32'(ring_done), 0);
    btn_snooze = 1'b1; cycle(); btn_snooze = 1'b0;
    check_output("idle_snz_ignored", 32'(snoozing), 0);
    check_output("idle_snz_active", 32'(ring_active), 0);
    ring_req = 1'b1; btn_stop = 1'b1; cycle(); ring_req = 1'b0; btn_stop = 1'b0;
    check_output("req_stop_active", 32'(ring_active), 1);
    check_output("req_stop_no_done", 32'(ring_done), 0);
    check_output("req_stop_timed_out", 32'(timed_out), 0);
    btn_snooze = 1'b1; cycle(); btn_snooze = 1'b0;
    check_output("snz_then_stop", 32'(snoozing), 1);
    btn_stop = 1'b1; cycle(); btn_stop = 1'b0;
    check_output("snz_stop_done", 32'(ring_done), 1);
    check_output("snz_stop_snoozing", 32'(snoozing), 0);
    check_output("snz_stop_left", 32'(snooze_left), 0);
    check_output("snz_stop_count", 32'(snooze_count), 0);
    btn_stop = 1'b1; cycle(); btn_stop = 1'b0;
    check_output("done_not_twice", 32'(ring_done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
